// File: rtl/task_fsm_pkg.sv
// ============================================================================
// task_fsm_pkg : lane state encoding and run-count helpers for task_fsm_bank
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package task_fsm_pkg;

    localparam logic [1:0] LANE_IDLE  = 2'b00;
    localparam logic [1:0] LANE_START = 2'b01;
    localparam logic [1:0] LANE_DONE  = 2'b10;
    localparam logic [1:0] LANE_WAIT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = LANE_IDLE,
        S_START = LANE_START,
        S_DONE  = LANE_DONE,
        S_WAIT  = LANE_WAIT
    } lane_state_t;

    // A zero run count from the global FSM still means one launch.
    function automatic logic [31:0] normalize_runs(input logic [31:0] runs);
        return (runs == 32'd0) ? 32'd1 : runs;
    endfunction

endpackage

`default_nettype wire

// File: rtl/task_fsm_lane.sv
// ============================================================================
// task_fsm_lane : one task lane - state register, run counter, start/done decode
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module task_fsm_lane
    import task_fsm_pkg::*;
#(
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              launch,
    input  logic [ITER_W-1:0] runs,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              global_done,
    output logic              ap_start,
    output logic              is_done,
    output logic              idle,
    output logic [ITER_W-1:0] run_idx
);

    lane_state_t       r_state;
    logic [ITER_W-1:0] r_run_idx;
    logic              w_last_run;

    assign w_last_run = (r_run_idx == (runs - ITER_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_run_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (launch) begin
                        r_state   <= S_START;
                        r_run_idx <= '0;
                    end
                end
                S_START: begin
                    if (ap_ready) begin
                        if (ap_done) begin
                            if (w_last_run) begin
                                r_state <= S_DONE;
                            end else begin
                                r_run_idx <= r_run_idx + ITER_W'(1);
                            end
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Next run re-enters START directly so there is no idle bubble.
                    if (ap_done) begin
                        if (w_last_run) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state   <= S_START;
                            r_run_idx <= r_run_idx + ITER_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (global_done) begin
                        r_state   <= S_IDLE;
                        r_run_idx <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ap_start = (r_state == S_START);
    assign is_done  = (r_state == S_DONE);
    assign idle     = (r_state == S_IDLE);
    assign run_idx  = r_run_idx;

endmodule

`default_nettype wire

// File: rtl/task_fsm_bank.sv
// ============================================================================
// task_fsm_bank : sequences NUM_TASKS task lanes from one global start/done pair
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module task_fsm_bank
    import task_fsm_pkg::*;
#(
    parameter int                   NUM_TASKS   = 4,
    parameter int                   SCALAR_W    = 32,
    parameter int                   NUM_SCALARS = 1,
    parameter int                   ITER_W      = 8,
    parameter logic [NUM_TASKS-1:0] DETACH_MASK = {NUM_TASKS{1'b0}}
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic [NUM_SCALARS*SCALAR_W-1:0] global_fsm_scalars,
    input  logic [ITER_W-1:0]               global_fsm_runs,
    input  logic                            global_fsm_ap_start,
    input  logic                            global_fsm_ap_done,
    output logic [NUM_SCALARS*SCALAR_W-1:0] task_scalars,
    output logic [NUM_TASKS*ITER_W-1:0]     task_run_idx,
    output logic [NUM_TASKS-1:0]            task_ap_start,
    input  logic [NUM_TASKS-1:0]            task_ap_ready,
    input  logic [NUM_TASKS-1:0]            task_ap_done,
    input  logic [NUM_TASKS-1:0]            task_ap_idle,
    output logic [NUM_TASKS-1:0]            to_global_fsm_is_done,
    output logic                            to_global_fsm_all_done,
    output logic                            bank_busy
);

    logic [NUM_SCALARS*SCALAR_W-1:0] r_scalars;
    logic [ITER_W-1:0]               r_runs;
    logic [ITER_W-1:0]               w_runs_norm;
    logic [NUM_TASKS-1:0]            w_lane_idle;
    logic                            w_launch;
    logic                            w_unused_idle;

    assign w_unused_idle = ^task_ap_idle;
    assign w_runs_norm   = ITER_W'(normalize_runs(32'(global_fsm_runs)));
    assign w_launch      = global_fsm_ap_start & ~bank_busy;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_scalars <= '0;
            r_runs    <= ITER_W'(1);
        end else if (w_launch) begin
            r_scalars <= global_fsm_scalars;
            r_runs    <= w_runs_norm;
        end
    end

    generate
        for (genvar i = 0; i < NUM_TASKS; i++) begin : g_lane
            task_fsm_lane #(
                .ITER_W (ITER_W)
            ) u_lane (
                .clk         (ap_clk),
                .rst_n       (ap_rst_n),
                .launch      (w_launch),
                .runs        (r_runs),
                .ap_ready    (task_ap_ready[i]),
                .ap_done     (task_ap_done[i]),
                .global_done (global_fsm_ap_done),
                .ap_start    (task_ap_start[i]),
                .is_done     (to_global_fsm_is_done[i]),
                .idle        (w_lane_idle[i]),
                .run_idx     (task_run_idx[i*ITER_W +: ITER_W])
            );
        end
    endgenerate

    assign task_scalars = r_scalars;
    assign bank_busy    = ~(&w_lane_idle);
    // Gated by bank_busy so an all-detached bank never reports done from IDLE.
    assign to_global_fsm_all_done = (&(to_global_fsm_is_done | DETACH_MASK)) & bank_busy;

endmodule

`default_nettype wire

// File: tb/tb_task_fsm_bank.sv
// ============================================================================
// tb_task_fsm_bank : directed bench for task_fsm_bank (plain and detached-lane3 builds)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_task_fsm_bank;

    logic        clk;
    logic        rst_n;
    logic [31:0] scalars;
    logic [7:0]  runs;
    logic        gstart;
    logic        gdone;
    logic [3:0]  ready;
    logic [3:0]  done;
    logic [3:0]  idle;

    logic [31:0] scal_a, scal_d;
    logic [31:0] idx_a, idx_d;
    logic [3:0]  start_a, start_d;
    logic [3:0]  isdone_a, isdone_d;
    logic        alldone_a, alldone_d;
    logic        busy_a, busy_d;

    int checks;
    int errors;

    task_fsm_bank #(.NUM_TASKS(4), .SCALAR_W(32), .NUM_SCALARS(1), .ITER_W(8),
                    .DETACH_MASK(4'b0000)) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .global_fsm_scalars(scalars), .global_fsm_runs(runs),
        .global_fsm_ap_start(gstart), .global_fsm_ap_done(gdone),
        .task_scalars(scal_a), .task_run_idx(idx_a), .task_ap_start(start_a),
        .task_ap_ready(ready), .task_ap_done(done), .task_ap_idle(idle),
        .to_global_fsm_is_done(isdone_a), .to_global_fsm_all_done(alldone_a),
        .bank_busy(busy_a)
    );

    task_fsm_bank #(.NUM_TASKS(4), .SCALAR_W(32), .NUM_SCALARS(1), .ITER_W(8),
                    .DETACH_MASK(4'b1000)) dut_d (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .global_fsm_scalars(scalars), .global_fsm_runs(runs),
        .global_fsm_ap_start(gstart), .global_fsm_ap_done(gdone),
        .task_scalars(scal_d), .task_run_idx(idx_d), .task_ap_start(start_d),
        .task_ap_ready(ready), .task_ap_done(done), .task_ap_idle(idle),
        .to_global_fsm_is_done(isdone_d), .to_global_fsm_all_done(alldone_d),
        .bank_busy(busy_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; scalars = 32'h0; runs = 8'd0; gstart = 1'b0; gdone = 1'b0;
        ready = 4'h0; done = 4'h0; idle = 4'h0;
        #3;
        checks++;
        if ({scal_a, idx_a, start_a, isdone_a, alldone_a, busy_a} !== 74'h0) begin
            $display("FAIL reset_a: got %h exp 0", {scal_a, idx_a, start_a, isdone_a, alldone_a, busy_a});
            errors++;
        end
        checks++;
        if ({scal_d, idx_d, start_d, isdone_d, alldone_d, busy_d} !== 74'h0) begin
            $display("FAIL reset_d: got %h exp 0", {scal_d, idx_d, start_d, isdone_d, alldone_d, busy_d});
            errors++;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_run;
        @(negedge clk);
        gstart = 1'b1; runs = 8'd1; scalars = 32'h0000_0001;
        @(negedge clk);
        gstart = 1'b0;
        checks++;
        if (start_a !== 4'b1111) begin
            $display("FAIL single_start: got %b exp 1111", start_a); errors++;
        end
        ready = 4'hF; done = 4'hF;
        @(negedge clk);
        checks++;
        if (isdone_a !== 4'b1111 || alldone_a !== 1'b1 || start_a !== 4'b0000) begin
            $display("FAIL single_done: is_done %b all %b start %b exp 1111 1 0000",
                     isdone_a, alldone_a, start_a); errors++;
        end
        ready = 4'h0; done = 4'h0; gdone = 1'b1;
        @(negedge clk);
        gdone = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || isdone_a !== 4'b0000 || alldone_a !== 1'b0) begin
            $display("FAIL single_release: busy %b is_done %b all %b exp 0 0000 0",
                     busy_a, isdone_a, alldone_a); errors++;
        end
    endtask

    task automatic test_multi_run;
        int pulses, cnt, dones0, early;
        logic [7:0] idx_seen [3];
        pulses = 0; cnt = 0; dones0 = 0; early = 0;
        for (int k = 0; k < 3; k++) idx_seen[k] = 8'hFF;
        @(negedge clk);
        gstart = 1'b1; runs = 8'd3; scalars = 32'h0000_0003;
        for (int cyc = 0; cyc < 40 && !alldone_a; cyc++) begin
            @(negedge clk);
            gstart = 1'b0;
            if (isdone_a[0] && dones0 != 3) early++;
            ready = 4'h0; done = 4'h0;
            if (start_a[0]) begin
                if (pulses < 3) idx_seen[pulses] = idx_a[7:0];
                pulses++;
                ready[0] = 1'b1;
                cnt = 2;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    done[0] = 1'b1;
                    dones0++;
                end
            end
            for (int i = 1; i < 4; i++) begin
                ready[i] = start_a[i];
                done[i]  = start_a[i];
            end
        end
        checks++;
        if (pulses != 3) begin
            $display("FAIL multi_pulses: got %0d exp 3", pulses); errors++;
        end
        checks++;
        if (idx_seen[0] !== 8'd0 || idx_seen[1] !== 8'd1 || idx_seen[2] !== 8'd2) begin
            $display("FAIL multi_run_idx: got %0d,%0d,%0d exp 0,1,2",
                     idx_seen[0], idx_seen[1], idx_seen[2]); errors++;
        end
        checks++;
        if (early != 0) begin
            $display("FAIL multi_early_done: got %0d early cycles exp 0", early); errors++;
        end
        checks++;
        if (alldone_a !== 1'b1 || isdone_a !== 4'b1111) begin
            $display("FAIL multi_all_done: all %b is_done %b exp 1 1111", alldone_a, isdone_a);
            errors++;
        end
        ready = 4'h0; done = 4'h0;
        @(negedge clk);
        gdone = 1'b1;
        @(negedge clk);
        gdone = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || busy_d !== 1'b0) begin
            $display("FAIL multi_release: busy %b/%b exp 0/0", busy_a, busy_d); errors++;
        end
    endtask

    task automatic test_runs_zero;
        @(negedge clk);
        gstart = 1'b1; runs = 8'd0; scalars = 32'hDEAD_BEEF;
        @(negedge clk);
        gstart = 1'b0;
        checks++;
        if (start_a !== 4'b1111 || idx_a !== 32'h0) begin
            $display("FAIL zero_launch: start %b idx %h exp 1111 0", start_a, idx_a); errors++;
        end
        // done without ready and an early global done must both be ignored
        scalars = 32'h1234_5678; ready = 4'h0; done = 4'hF; gdone = 1'b1;
        @(negedge clk);
        checks++;
        if (start_a !== 4'b1111 || scal_a !== 32'hDEAD_BEEF || busy_a !== 1'b1) begin
            $display("FAIL zero_hold: start %b scalars %h busy %b exp 1111 deadbeef 1",
                     start_a, scal_a, busy_a); errors++;
        end
        gdone = 1'b0; ready = 4'hF; done = 4'hF;
        @(negedge clk);
        checks++;
        if (isdone_a !== 4'b1111 || start_a !== 4'b0000 || scal_a !== 32'hDEAD_BEEF) begin
            $display("FAIL zero_one_run: is_done %b start %b scalars %h exp 1111 0000 deadbeef",
                     isdone_a, start_a, scal_a); errors++;
        end
        ready = 4'h0; done = 4'h0; gdone = 1'b1;
        @(negedge clk);
        gdone = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin
            $display("FAIL zero_release: busy %b exp 0", busy_a); errors++;
        end
    endtask

    task automatic test_detach;
        @(negedge clk);
        gstart = 1'b1; runs = 8'd1; scalars = 32'h0000_1111;
        @(negedge clk);
        gstart = 1'b0;
        ready = 4'hF; done = 4'b0111;
        @(negedge clk);
        checks++;
        if (alldone_d !== 1'b1 || isdone_d !== 4'b0111) begin
            $display("FAIL detach_all_done: all %b is_done %b exp 1 0111", alldone_d, isdone_d);
            errors++;
        end
        checks++;
        if (alldone_a !== 1'b0) begin
            $display("FAIL attached_gates: all %b exp 0", alldone_a); errors++;
        end
        ready = 4'h0; done = 4'h0; gdone = 1'b1;
        @(negedge clk);
        gdone = 1'b0;
        checks++;
        if (isdone_d !== 4'b0000 || busy_d !== 1'b1 || alldone_d !== 1'b0 || start_d !== 4'b0000) begin
            $display("FAIL detach_after_gdone: is_done %b busy %b all %b start %b exp 0000 1 0 0000",
                     isdone_d, busy_d, alldone_d, start_d); errors++;
        end
        gstart = 1'b1; runs = 8'd2; scalars = 32'hCAFE_F00D;
        @(negedge clk);
        gstart = 1'b0;
        checks++;
        if (start_d !== 4'b0000 || scal_d !== 32'h0000_1111 || start_a !== 4'b0000) begin
            $display("FAIL detach_restart_ignored: start %b/%b scalars %h exp 0000/0000 00001111",
                     start_d, start_a, scal_d); errors++;
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || busy_d !== 1'b1) begin
            $display("FAIL pre_reset_busy: busy %b/%b exp 1/1", busy_a, busy_d); errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({start_a, isdone_a, alldone_a, busy_a, start_d, isdone_d, alldone_d, busy_d} !== 20'h0) begin
            $display("FAIL async_reset: got %h exp 0",
                     {start_a, isdone_a, alldone_a, busy_a, start_d, isdone_d, alldone_d, busy_d});
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        gstart = 1'b1; runs = 8'd1; scalars = 32'h0BAD_CAFE;
        @(negedge clk);
        gstart = 1'b0;
        checks++;
        if (start_d !== 4'b1111 || idx_d !== 32'h0 || scal_d !== 32'h0BAD_CAFE) begin
            $display("FAIL relaunch: start %b idx %h scalars %h exp 1111 0 0badcafe",
                     start_d, idx_d, scal_d); errors++;
        end
        ready = 4'hF; done = 4'hF;
        @(negedge clk);
        checks++;
        if (alldone_a !== 1'b1 || alldone_d !== 1'b1 || isdone_d !== 4'b1111) begin
            $display("FAIL relaunch_done: all %b/%b is_done %b exp 1/1 1111",
                     alldone_a, alldone_d, isdone_d); errors++;
        end
        ready = 4'h0; done = 4'h0; gdone = 1'b1;
        @(negedge clk);
        gdone = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || busy_d !== 1'b0) begin
            $display("FAIL relaunch_release: busy %b/%b exp 0/0", busy_a, busy_d); errors++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_run();
        test_multi_run();
        test_runs_zero();
        test_detach();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
